// File: rtl/mcu_transpose_buf.sv
// Ping-pong 8x8 transpose buffer between the MCU line buffer and the column-first 1D DCT.
// Rows are written into one bank while the other bank is read out column by column.
module mcu_transpose_buf #(
  parameter int unsigned DW        = 8,
  parameter int unsigned CHECK_ROW = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0][DW-1:0] di,
  input  logic               di_valid,
  output logic               di_hold,
  input  logic [2:0]         di_cnt,
  output logic [7:0][DW-1:0] do_data,
  output logic               do_valid,
  input  logic               do_hold,
  output logic [2:0]         do_cnt,
  output logic               do_last,
  output logic               row_err
);

  localparam int unsigned NB = 2;
  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;

  logic [DW-1:0] mem [NB][N][N];
  logic [NB-1:0] bank_full;
  logic          wbank;
  logic          rbank;
  logic [IW-1:0] wrow;
  logic [IW-1:0] rcol;
  logic          wr_xfer;
  logic          rd_xfer;

  // Handshake state comes straight from flags, so di_hold has no path from di_valid.
  assign di_hold  = bank_full[wbank];
  assign do_valid = bank_full[rbank];
  assign wr_xfer  = di_valid & ~di_hold;
  assign rd_xfer  = do_valid & ~do_hold;
  assign do_cnt   = rcol;
  assign do_last  = do_valid & (rcol == IW'(N - 1));

  // Column read: row j of column rcol from the bank being drained.
  always_comb begin
    do_data = '0;
    for (int j = 0; j < int'(N); j++) begin
      do_data[j] = mem[rbank][j][rcol];
    end
  end

  // Sample storage carries no reset; validity is tracked by bank_full alone.
  always_ff @(posedge clk) begin
    if (wr_xfer) begin
      for (int i = 0; i < int'(N); i++) begin
        mem[wbank][wrow][i] <= di[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_full <= '0;
      wbank     <= 1'b0;
      rbank     <= 1'b0;
      wrow      <= '0;
      rcol      <= '0;
      row_err   <= 1'b0;
    end else begin
      if (wr_xfer) begin
        wrow <= IW'(wrow + IW'(1));
        if (wrow == IW'(N - 1)) begin
          bank_full[wbank] <= 1'b1;
          wbank            <= ~wbank;
        end
        if ((CHECK_ROW != 0) && (di_cnt != wrow)) begin
          row_err <= 1'b1;
        end
      end
      // Writer and reader always touch different banks when both complete together.
      if (rd_xfer) begin
        rcol <= IW'(rcol + IW'(1));
        if (rcol == IW'(N - 1)) begin
          bank_full[rbank] <= 1'b0;
          rbank            <= ~rbank;
        end
      end
    end
  end

endmodule
